// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Optional feature macro: MUX_SEL_OVERRIDE_EN (forced channel select).
package stream_mux_pkg;

    // Output register occupancy: EMPTY means out_valid low, FULL means a beat is held.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Channel index width: clog2 of the channel count, never below one bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches requests starting at the
// pointer and wrapping modulo NUM_CH; returns one-hot grant plus its index.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);

    logic [CH_W-1:0] w_cand;

    // First requester at or after the pointer wins; later candidates are ignored once o_any is set.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = CH_W'((int'(i_ptr) + i) % NUM_CH);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration and a
// registered output stage. Each output beat is tagged with its source channel.
// Optional feature macro: MUX_SEL_OVERRIDE_EN adds sel_en/sel to force a channel.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
`ifdef MUX_SEL_OVERRIDE_EN
    ,
    input  logic                     sel_en,
    input  logic [CH_W-1:0]          sel
`endif
);

    out_state_t          r_state;
    out_state_t          w_state_next;
    logic [CH_W-1:0]     r_ptr;
    logic [DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]     r_out_ch;

    logic                w_load;
    logic [NUM_CH-1:0]   w_arb_grant;
    logic [CH_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [NUM_CH-1:0]   w_grant;
    logic [CH_W-1:0]     w_idx;
    logic                w_any;
    logic                w_ptr_upd;
    logic                w_fire;
    logic [DATA_W-1:0]   w_data_sel;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Choose between the round-robin grant and, when enabled, a forced channel that leaves the pointer frozen.
    always_comb begin
        w_grant   = w_arb_grant;
        w_idx     = w_arb_idx;
        w_any     = w_arb_any;
        w_ptr_upd = 1'b1;
`ifdef MUX_SEL_OVERRIDE_EN
        if (sel_en) begin
            w_grant   = '0;
            w_idx     = sel;
            w_any     = 1'b0;
            w_ptr_upd = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if ((sel == CH_W'(k)) && in_valid[k]) begin
                    w_grant[k] = 1'b1;
                    w_any      = 1'b1;
                end
            end
        end
`endif
    end

    assign w_load   = !out_valid || out_ready;
    assign in_ready = w_load ? w_grant : '0;
    assign w_fire   = w_load && w_any;

    // Select the granted channel's data slice for loading into the output register.
    always_comb begin
        w_data_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_idx == CH_W'(k)) begin
                w_data_sel = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output-stage occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy next state: fill on a transfer, drain when consumed with nothing to refill.
    always_comb begin
        w_state_next = r_state;
        out_valid    = (r_state == ST_FULL);
        case (r_state)
            ST_EMPTY: begin
                if (w_fire) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    w_state_next = w_fire ? ST_FULL : ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Capture the granted beat and advance the round-robin pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_ptr      <= '0;
        end else if (w_fire) begin
            r_out_data <= w_data_sel;
            r_out_ch   <= w_idx;
            if (w_ptr_upd) begin
                r_ptr <= (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_ch   = r_out_ch;

endmodule
